trigger_from_pulse: RTL and testbench

TRIGGER_FROM_PULSE -- requirements
Module: trigger_from_pulse

---
 rtl/trigger_from_pulse.sv | 129 ++++++++++++
 tb/tb_trigger_from_pulse.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/trigger_from_pulse.sv
// rtl/trigger_from_pulse.sv - pulse-to-level trigger generator with retrigger, holdoff and drop counting
module trigger_from_pulse #(
    parameter int CNT_W  = 8,
    parameter int DROP_W = 4
) (
    input  logic              clk,
    input  logic              reset_x,
    input  logic              clk_enable,
    input  logic              pulse_in,
    input  logic [CNT_W-1:0]  hold_len,
    input  logic [CNT_W-1:0]  holdoff_len,
    input  logic              retrig_en,
    output logic              ce_out,
    output logic              trig_out,
    output logic              busy,
    output logic              done,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]    hoff_cnt_q, hoff_cnt_d;
    logic                trig_q, trig_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic [CNT_W-1:0]    hold_load;
    logic                drop_inc;

    assign hold_load = (hold_len == '0) ? CNT_W'(1) : hold_len;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        hoff_cnt_d = hoff_cnt_q;
        trig_d     = trig_q;
        done_d     = done_q;
        drop_inc   = 1'b0;
        if (clk_enable) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (pulse_in) begin
                        state_d    = ACTIVE;
                        hold_cnt_d = hold_load;
                        trig_d     = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (pulse_in && retrig_en) begin
                        hold_cnt_d = hold_load;
                    end else begin
                        drop_inc = pulse_in;
                        if (hold_cnt_q <= CNT_W'(1)) begin
                            hold_cnt_d = '0;
                            trig_d     = 1'b0;
                            done_d     = 1'b1;
                            if (holdoff_len != '0) begin
                                state_d    = HOLDOFF;
                                hoff_cnt_d = holdoff_len;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            hold_cnt_d = hold_cnt_q - CNT_W'(1);
                        end
                    end
                end
                HOLDOFF: begin
                    // The edge closing the last holdoff cycle may already accept a new pulse.
                    if (hoff_cnt_q <= CNT_W'(1)) begin
                        hoff_cnt_d = '0;
                        if (pulse_in) begin
                            state_d    = ACTIVE;
                            hold_cnt_d = hold_load;
                            trig_d     = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        hoff_cnt_d = hoff_cnt_q - CNT_W'(1);
                        drop_inc   = pulse_in;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    hoff_cnt_d = '0;
                    trig_d     = 1'b0;
                end
            endcase
        end
        drop_d = (drop_inc && (drop_q != {DROP_W{1'b1}})) ? drop_q + DROP_W'(1) : drop_q;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            hoff_cnt_q <= '0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            hoff_cnt_q <= hoff_cnt_d;
            trig_q     <= trig_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign ce_out   = clk_enable;
    assign trig_out = trig_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_trigger_from_pulse.sv
// tb/tb_trigger_from_pulse.sv - table-driven bench for trigger_from_pulse
module tb_trigger_from_pulse;

    logic       clk = 1'b0;
    logic       reset_x;
    logic       clk_enable;
    logic       pulse_in;
    logic [7:0] hold_len;
    logic [7:0] holdoff_len;
    logic       retrig_en;
    logic       ce_out;
    logic       trig_out;
    logic       busy;
    logic       done;
    logic [3:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       ce;
        logic       pulse;
        logic       retrig;
        logic [7:0] hold;
        logic [7:0] hoff;
        logic       e_trig;
        logic       e_busy;
        logic       e_done;
        logic [3:0] e_drop;
    } vec_t;

    vec_t vecs[$];

    trigger_from_pulse #(.CNT_W(8), .DROP_W(4)) dut (
        .clk         (clk),
        .reset_x     (reset_x),
        .clk_enable  (clk_enable),
        .pulse_in    (pulse_in),
        .hold_len    (hold_len),
        .holdoff_len (holdoff_len),
        .retrig_en   (retrig_en),
        .ce_out      (ce_out),
        .trig_out    (trig_out),
        .busy        (busy),
        .done        (done),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ce, input logic p, input logic r, input logic [7:0] h,
                       input logic [7:0] o, input logic et, input logic eb, input logic ed,
                       input logic [3:0] edrp);
        vec_t v;
        v.ce = ce; v.pulse = p; v.retrig = r; v.hold = h; v.hoff = o;
        v.e_trig = et; v.e_busy = eb; v.e_done = ed; v.e_drop = edrp;
        vecs.push_back(v);
    endtask

    initial begin
        int hi;
        reset_x     = 1'b0;
        clk_enable  = 1'b0;
        pulse_in    = 1'b0;
        hold_len    = 8'd0;
        holdoff_len = 8'd0;
        retrig_en   = 1'b0;
        #1;
        check("rst_trig", trig_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ce_lo", ce_out, 0);
        clk_enable = 1'b1;
        #1;
        check("rst_ce_hi", ce_out, 1);
        tick();
        tick();
        reset_x = 1'b1;

        // single trigger, hold 3; hold_len changed mid-count must not matter
        add(1,1,0,3,0, 1,1,0,0);
        add(1,0,0,7,0, 1,1,0,0);
        add(1,0,0,7,0, 1,1,0,0);
        add(1,0,0,3,0, 0,0,1,0);
        add(1,0,0,3,0, 0,0,0,0);
        // retrigger extends, hold 4
        add(1,1,1,4,0, 1,1,0,0);
        add(1,0,1,4,0, 1,1,0,0);
        add(1,1,1,4,0, 1,1,0,0);
        add(1,0,1,4,0, 1,1,0,0);
        add(1,0,1,4,0, 1,1,0,0);
        add(1,0,1,4,0, 1,1,0,0);
        add(1,0,1,4,0, 0,0,1,0);
        add(1,0,1,4,0, 0,0,0,0);
        // hold 2, holdoff 3, drops in active and holdoff
        add(1,1,0,2,3, 1,1,0,0);
        add(1,1,0,2,3, 1,1,0,1);
        add(1,0,0,2,3, 0,1,1,1);
        add(1,1,0,2,3, 0,1,0,2);
        add(1,0,0,2,3, 0,1,0,2);
        add(1,0,0,2,3, 0,0,0,2);
        // hold 0 acts as 1; pulse in done cycle accepted with no holdoff
        add(1,1,0,0,0, 1,1,0,2);
        add(1,0,0,0,0, 0,0,1,2);
        add(1,1,0,0,0, 1,1,0,2);
        add(1,0,0,0,0, 0,0,1,2);
        add(1,0,0,0,0, 0,0,0,2);
        // clock enable gaps stretch the trigger and freeze done
        add(1,1,0,4,0, 1,1,0,2);
        add(0,1,0,4,0, 1,1,0,2);
        add(0,0,0,4,0, 1,1,0,2);
        add(0,1,0,4,0, 1,1,0,2);
        add(0,0,0,4,0, 1,1,0,2);
        add(0,0,0,4,0, 1,1,0,2);
        add(1,0,0,4,0, 1,1,0,2);
        add(1,0,0,4,0, 1,1,0,2);
        add(1,0,0,4,0, 1,1,0,2);
        add(1,0,0,4,0, 0,0,1,2);
        add(0,0,0,4,0, 0,0,1,2);
        add(1,0,0,4,0, 0,0,0,2);
        // retrigger on the final high cycle leaves no gap
        add(1,1,1,2,0, 1,1,0,2);
        add(1,0,1,2,0, 1,1,0,2);
        add(1,1,1,2,0, 1,1,0,2);
        add(1,0,1,2,0, 1,1,0,2);
        add(1,0,1,2,0, 0,0,1,2);
        add(1,0,1,2,0, 0,0,0,2);

        foreach (vecs[i]) begin
            clk_enable  = vecs[i].ce;
            pulse_in    = vecs[i].pulse;
            retrig_en   = vecs[i].retrig;
            hold_len    = vecs[i].hold;
            holdoff_len = vecs[i].hoff;
            tick();
            check($sformatf("row%0d_trig", i), trig_out, vecs[i].e_trig);
            check($sformatf("row%0d_busy", i), busy,     vecs[i].e_busy);
            check($sformatf("row%0d_done", i), done,     vecs[i].e_done);
            check($sformatf("row%0d_drop", i), drop_cnt, vecs[i].e_drop);
        end

        // drop counter saturation: long trigger, 20 ignored pulses
        clk_enable = 1'b1;
        retrig_en  = 1'b0;
        hold_len   = 8'd100;
        pulse_in   = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) tick();
        check("sat_drop", drop_cnt, 15);
        check("sat_trig", trig_out, 1);

        // async reset mid-active
        pulse_in = 1'b0;
        #3;
        reset_x = 1'b0;
        #1;
        check("arst_trig", trig_out, 0);
        check("arst_busy", busy, 0);
        check("arst_drop", drop_cnt, 0);
        check("arst_done", done, 0);
        tick();
        tick();
        check("arst_hold_done", done, 0);
        reset_x  = 1'b1;
        hold_len = 8'd5;
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (!trig_out) break;
            hi++;
            tick();
        end
        check("post_rst_len", hi, 5);
        check("post_rst_done", done, 1);
        check("post_rst_drop", drop_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
